led_pulse_stretch: RTL and testbench

Output-side counterpart to the board's push-button input conditioning: drives the ML605 user LEDs from fast internal status. One-cycle events are stretched to a visible minimum on-time; levels are passed through or blinked. Sits between the SoftMC control logic and the GPIO LED pins, with one clock and no handshake back to the sources.

---
 rtl/led_pkg.sv | 35 +++
 rtl/led_chan.sv | 69 ++++++
 rtl/led_pulse_stretch.sv | 76 +++++++
 tb/tb_led_pulse_stretch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED output conditioning block: channel mode encodings,
// default timing constants and the per-channel output mux.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_LEVEL   = 2'b01,
        LED_STRETCH = 2'b10,
        LED_BLINK   = 2'b11
    } led_mode_e;

    localparam int unsigned LED_PBITS_DEF     = 24;
    localparam int unsigned LED_HBITS_DEF     = 8;
    localparam logic [23:0] LED_PRESCALE_DEF  = 24'd100_000;
    localparam logic [7:0]  LED_HOLD_DEF      = 8'd100;
    localparam logic [7:0]  LED_BLINK_DEF     = 8'd250;

    // LED drive for one channel given its registered mode and status terms.
    function automatic logic led_drive(input led_mode_e mode,
                                       input logic      level,
                                       input logic      stretch_on,
                                       input logic      phase);
        logic drive;
        drive = 1'b0;
        unique case (mode)
            LED_OFF:     drive = 1'b0;
            LED_LEVEL:   drive = level;
            LED_STRETCH: drive = stretch_on;
            LED_BLINK:   drive = level & phase;
            default:     drive = 1'b0;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: input registers, hold counter for event stretching, mode mux and
// registered LED output. Tick and blink phase come from the shared timebase.
module led_chan
    import led_pkg::*;
#(
    parameter int unsigned       HBITS      = LED_HBITS_DEF,
    parameter logic [HBITS-1:0]  HOLD_TICKS = LED_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_i,
    input  logic       blink_phase_i,
    input  logic       evt_i,
    input  logic       level_i,
    input  logic [1:0] mode_i,
    output logic       led_o
);

    logic             evt_d, evt_q;
    logic             level_d, level_q;
    led_mode_e        mode_d, mode_q;
    led_mode_e        mode_prev_d, mode_prev_q;
    logic [HBITS-1:0] hold_d, hold_q;
    logic             led_d, led_q;
    logic             mode_chg;

    always_comb begin
        evt_d       = evt_i;
        level_d     = level_i;
        mode_d      = led_mode_e'(mode_i);
        mode_prev_d = mode_q;
        mode_chg    = (mode_q != mode_prev_q);

        // Load beats both the tick decrement and a mode-change clear.
        hold_d = hold_q;
        if (mode_q != LED_STRETCH) begin
            hold_d = '0;
        end else if (evt_q) begin
            hold_d = HOLD_TICKS;
        end else if (mode_chg) begin
            hold_d = '0;
        end else if (tick_i && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end

        led_d = led_drive(mode_q, level_q, (hold_d != '0), blink_phase_i);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            evt_q       <= 1'b0;
            level_q     <= 1'b0;
            mode_q      <= LED_OFF;
            mode_prev_q <= LED_OFF;
            hold_q      <= '0;
            led_q       <= 1'b0;
        end else begin
            evt_q       <= evt_d;
            level_q     <= level_d;
            mode_q      <= mode_d;
            mode_prev_q <= mode_prev_d;
            hold_q      <= hold_d;
            led_q       <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pulse_stretch.sv
// Drives the user LEDs from fast internal status: shared prescaler and blink generator
// feeding NCH independent stretch/level/blink channels.
module led_pulse_stretch
    import led_pkg::*;
#(
    parameter int unsigned       NCH         = 8,
    parameter int unsigned       PBITS       = LED_PBITS_DEF,
    parameter logic [PBITS-1:0]  PRESCALE    = LED_PRESCALE_DEF,
    parameter int unsigned       HBITS       = LED_HBITS_DEF,
    parameter logic [HBITS-1:0]  HOLD_TICKS  = LED_HOLD_DEF,
    parameter logic [HBITS-1:0]  BLINK_TICKS = LED_BLINK_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   evt_i,
    input  logic [NCH-1:0]   level_i,
    input  logic [2*NCH-1:0] mode_i,
    output logic [NCH-1:0]   led_o,
    output logic             tick_o
);

    localparam logic [PBITS-1:0] PMAX = PRESCALE - 1'b1;
    localparam logic [HBITS-1:0] BMAX = BLINK_TICKS - 1'b1;

    logic [PBITS-1:0] pcnt_d, pcnt_q;
    logic [HBITS-1:0] bcnt_d, bcnt_q;
    logic             phase_d, phase_q;
    logic             tick;

    always_comb begin
        tick   = (pcnt_q == PMAX);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (bcnt_q == BMAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign tick_o = tick;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        led_chan #(
            .HBITS      (HBITS),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .tick_i        (tick),
            .blink_phase_i (phase_q),
            .evt_i         (evt_i[k]),
            .level_i       (level_i[k]),
            .mode_i        (mode_i[2*k +: 2]),
            .led_o         (led_o[k])
        );
    end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed and random checks of led_pulse_stretch against a time-based reference model
// derived from input history (ticks and blink phase computed arithmetically).
module tb_led_pulse_stretch;

    localparam int NCH  = 4;
    localparam int P    = 4;
    localparam int H    = 3;
    localparam int B    = 2;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] evt_i, level_i, led_o;
    logic [7:0] mode_i;
    logic       tick_o;

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .NCH         (NCH),
        .PRESCALE    (24'd4),
        .HOLD_TICKS  (8'd3),
        .BLINK_TICKS (8'd2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .evt_i   (evt_i),
        .level_i (level_i),
        .mode_i  (mode_i),
        .led_o   (led_o),
        .tick_o  (tick_o)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;
    int on_cnt = 0;
    logic [3:0] evt_h  [MAXC];
    logic [3:0] lvl_h  [MAXC];
    logic [7:0] mode_h [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Ticks occurring in cycles a..b; a tick is the cycle where t mod P == P-1.
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / P - a / P;
    endfunction

    function automatic logic [1:0] mode_at(input int c, input int ch);
        logic [7:0] m;
        if (c < 1) return 2'b00;
        m = mode_h[c-1];
        return m[2*ch +: 2];
    endfunction

    // Blink phase held during cycle c: one toggle per B completed ticks.
    function automatic logic phase_at(input int c);
        return (((c / P) / B) % 2) == 1;
    endfunction

    function automatic logic exp_led(input int tt, input int ch);
        int s;
        logic [1:0] m;
        logic [3:0] v;
        if (tt < 2) return 1'b0;
        s = tt - 1;
        m = mode_at(s, ch);
        v = lvl_h[s-1];
        case (m)
            2'b00: return 1'b0;
            2'b01: return v[ch];
            2'b11: return v[ch] & phase_at(s);
            default: begin
                // Latest load in an unbroken STRETCH run, lit while fewer than H ticks since.
                for (int l = s; l >= 1; l--) begin
                    logic [3:0] e;
                    if (mode_at(l, ch) != 2'b10) return 1'b0;
                    if (ticks_in(l + 1, s) >= H) return 1'b0;
                    e = evt_h[l-1];
                    if (e[ch]) return 1'b1;
                end
                return 1'b0;
            end
        endcase
    endfunction

    task automatic cyc(input logic [3:0] e, input logic [3:0] l, input logic [7:0] m);
        logic [3:0] exp;
        for (int ch = 0; ch < NCH; ch++) exp[ch] = exp_led(t, ch);
        chk("led_o", {28'd0, led_o}, {28'd0, exp});
        chk("tick_o", {31'd0, tick_o}, {31'd0, (t % P) == P - 1});
        on_cnt += int'(led_o[0]);
        evt_i     = e;
        level_i   = l;
        mode_i    = m;
        evt_h[t]  = e;
        lvl_h[t]  = l;
        mode_h[t] = m;
        @(posedge clk);
        #1;
        t++;
        if (t >= MAXC) begin
            $display("FAIL history_bound: cycle %0d exceeds %0d", t, MAXC);
            $fatal(1, "history overflow");
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        evt_i   = '1;
        level_i = '1;
        mode_i  = '1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_led", {28'd0, led_o}, 32'd0);
            chk("rst_tick", {31'd0, tick_o}, 32'd0);
        end
        reset_n = 1'b1;
        t = 0;
    endtask

    logic [3:0] re, rl;
    logic [7:0] rm;
    logic       prev2;
    int         last_tog, ntog;

    initial begin
        evt_i   = '0;
        level_i = '0;
        mode_i  = '0;

        // Reset with inputs high, then prescaler ticks and a single stretch on ch0.
        do_reset(5);
        on_cnt = 0;
        while (t < 30) cyc((t == 10) ? 4'b0001 : 4'b0000, 4'b0000, 8'h02);
        chk("stretch_on_count", on_cnt, 12);
        chk("stretch_on_window", {31'd0, (on_cnt >= 9) && (on_cnt <= 12)}, 32'd1);

        // Retrigger while lit with the event landing on a tick cycle.
        while (t < 32) cyc((t == 30) ? 4'b0001 : 4'b0000, 4'b0000, 8'h02);
        on_cnt = 0;
        while (t < 56) cyc((t == 34) ? 4'b0001 : 4'b0000, 4'b0000, 8'h02);
        chk("retrigger_on_count", on_cnt, 16);

        // LEVEL on ch1, BLINK on ch2.
        prev2    = led_o[2];
        last_tog = -1;
        ntog     = 0;
        repeat (48) begin
            cyc(4'b0000, 4'b0110, 8'h34);
            if (led_o[2] !== prev2) begin
                ntog++;
                if (ntog >= 3) chk("blink_half_period", t - last_tog, 8);
                last_tog = t;
                prev2    = led_o[2];
            end
        end
        chk("blink_toggled", {31'd0, ntog >= 4}, 32'd1);
        repeat (2) cyc(4'b0000, 4'b0000, 8'h34);
        chk("level_drop", {30'd0, led_o[2:1]}, 32'd0);

        // STRETCH -> OFF -> STRETCH without a fresh event stays dark.
        repeat (2) cyc(4'b0000, 4'b0000, 8'h02);
        cyc(4'b0001, 4'b0000, 8'h02);
        repeat (3) cyc(4'b0000, 4'b0000, 8'h02);
        chk("stretch_lit", {31'd0, led_o[0]}, 32'd1);
        repeat (3) cyc(4'b0000, 4'b0000, 8'h00);
        repeat (20) cyc(4'b0000, 4'b0000, 8'h02);
        chk("stretch_after_off", {31'd0, led_o[0]}, 32'd0);

        // Reset mid-blink; model restarts phase from the new epoch.
        repeat (20) cyc(4'b0000, 4'b0100, 8'h30);
        do_reset(1);
        repeat (30) cyc(4'b0000, 4'b0100, 8'h30);

        // OFF channel ignores events and levels.
        repeat (50) begin
            cyc(4'b1000, 4'b1000, 8'h00);
            chk("off_led3", {31'd0, led_o[3]}, 32'd0);
        end

        // Random traffic, including a reset in the middle.
        rl = '0;
        rm = 8'h00;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(2);
            for (int i = 0; i < 1500; i++) begin
                for (int ch = 0; ch < NCH; ch++) re[ch] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 15) == 0) rl = 4'($urandom);
                if ($urandom_range(0, 39) == 0) rm = 8'($urandom);
                cyc(re, rl, rm);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
